// File: rtl/universal_shift_register.sv
// Universal shift register: single-cycle shift, rotate and load operations, plus a
// serial burst engine that shifts Count bits out of Q[0] and then pulses Done.
module universal_shift_register #(
  parameter int N  = 8,
  parameter int AW = 4,
  parameter int CW = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [N-1:0]  I,
  input  logic [2:0]    Mode,
  input  logic [AW-1:0] Amount,
  input  logic          W,
  input  logic          Start,
  input  logic [CW-1:0] Count,
  output logic [N-1:0]  Q,
  output logic          SerialOut,
  output logic          Busy,
  output logic          Done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_SHL  = 3'd1;
  localparam logic [2:0] M_SHR  = 3'd2;
  localparam logic [2:0] M_ASR  = 3'd3;
  localparam logic [2:0] M_ROL  = 3'd4;
  localparam logic [2:0] M_ROR  = 3'd5;
  localparam logic [2:0] M_LOAD = 3'd6;

  state_t        state;
  logic [N-1:0]  q;
  logic [CW-1:0] rem;
  logic          busy;
  logic          done;

  // Shifts by >= N fall out naturally: the data term becomes zero and the fill mask all ones.
  function automatic logic [N-1:0] shift_left(input logic [N-1:0] d,
                                              input logic [AW-1:0] amt,
                                              input logic fill);
    logic [N-1:0] ones;
    ones = '1;
    return (d << amt) | (~(ones << amt) & {N{fill}});
  endfunction

  function automatic logic [N-1:0] shift_right(input logic [N-1:0] d,
                                               input logic [AW-1:0] amt,
                                               input logic fill);
    logic [N-1:0] ones;
    ones = '1;
    return (d >> amt) | (~(ones >> amt) & {N{fill}});
  endfunction

  function automatic logic [N-1:0] rotate_left(input logic [N-1:0] d,
                                               input logic [AW-1:0] amt);
    logic [31:0]    r;
    logic [2*N-1:0] dd;
    r  = 32'(amt) % 32'(N);
    dd = {d, d} << r;
    return dd[2*N-1:N];
  endfunction

  function automatic logic [N-1:0] rotate_right(input logic [N-1:0] d,
                                                input logic [AW-1:0] amt);
    logic [31:0]    r;
    logic [2*N-1:0] dd;
    r  = 32'(amt) % 32'(N);
    dd = {d, d} >> r;
    return dd[N-1:0];
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      q     <= '0;
      rem   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            rem <= Count;
            if (Count != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end else begin
            case (Mode)
              M_SHL:   q <= shift_left(q, Amount, W);
              M_SHR:   q <= shift_right(q, Amount, W);
              M_ASR:   q <= shift_right(q, Amount, q[N-1]);
              M_ROL:   q <= rotate_left(q, Amount);
              M_ROR:   q <= rotate_right(q, Amount);
              M_LOAD:  q <= I;
              M_HOLD:  q <= q;
              default: q <= q;
            endcase
          end
        end
        RUN: begin
          // Burst shifting ignores Mode/Amount/I/Start; the last shift happens on the Rem=1 edge.
          q   <= {W, q[N-1:1]};
          rem <= rem - CW'(1);
          if (rem == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Q         = q;
  assign SerialOut = q[0];
  assign Busy      = busy;
  assign Done      = done;

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register: directed vector table, hand-written burst
// sequences and a randomized run against an arithmetic reference model.
module tb_universal_shift_register;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] I;
  logic [2:0] Mode;
  logic [3:0] Amount;
  logic       W;
  logic       Start;
  logic [3:0] Count;
  logic [7:0] Q;
  logic       SerialOut;
  logic       Busy;
  logic       Done;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  universal_shift_register #(.N(8), .AW(4), .CW(4)) dut (
    .Clock(Clock), .Reset(Reset), .I(I), .Mode(Mode), .Amount(Amount), .W(W),
    .Start(Start), .Count(Count), .Q(Q), .SerialOut(SerialOut), .Busy(Busy), .Done(Done)
  );

  typedef struct {
    string      name;
    logic [7:0] q0;
    logic [2:0] mode;
    logic [3:0] amt;
    logic       w;
    logic [7:0] i;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    Reset = 1'b0; Start = 1'b0; Mode = 3'd0; Amount = 4'd0; W = 1'b0; Count = 4'd0; I = 8'h00;
  endtask

  task automatic load(input logic [7:0] v);
    Mode = 3'd6; I = v;
    step();
    Mode = 3'd0;
  endtask

  // Reference model for single-cycle modes, written with plain integer arithmetic.
  function automatic int model_op(int q, int mode, int amt, int w, int i);
    int p, r, fill;
    p = 1 << amt;
    case (mode)
      1: return (amt >= 8) ? (w != 0 ? 255 : 0) : ((q * p) % 256) + (w != 0 ? p - 1 : 0);
      2, 3: begin
        fill = (mode == 3) ? (q >= 128 ? 1 : 0) : w;
        if (amt >= 8) return fill != 0 ? 255 : 0;
        return q / p + (fill != 0 ? 256 - 256 / p : 0);
      end
      4: begin
        r = amt % 8;
        return ((q * (1 << r)) % 256) + q / (1 << (8 - r));
      end
      5: begin
        r = amt % 8;
        return q / (1 << r) + (q % (1 << r)) * (1 << (8 - r));
      end
      6: return i;
      default: return q;
    endcase
  endfunction

  initial begin
    vecs[0]  = '{"load_a5",  8'h00, 3'd6, 4'd0,  1'b0, 8'hA5, 8'hA5};
    vecs[1]  = '{"hold0",    8'hA5, 3'd0, 4'd5,  1'b1, 8'h00, 8'hA5};
    vecs[2]  = '{"hold7",    8'h5A, 3'd7, 4'd3,  1'b1, 8'hFF, 8'h5A};
    vecs[3]  = '{"shl3_w1",  8'h01, 3'd1, 4'd3,  1'b1, 8'h00, 8'h0F};
    vecs[4]  = '{"asr2",     8'h90, 3'd3, 4'd2,  1'b0, 8'h00, 8'hE4};
    vecs[5]  = '{"rol9",     8'h81, 3'd4, 4'd9,  1'b0, 8'h00, 8'h03};
    vecs[6]  = '{"ror1",     8'h81, 3'd5, 4'd1,  1'b0, 8'h00, 8'hC0};
    vecs[7]  = '{"shl9_w1",  8'h12, 3'd1, 4'd9,  1'b1, 8'h00, 8'hFF};
    vecs[8]  = '{"shr3_w1",  8'h96, 3'd2, 4'd3,  1'b1, 8'h00, 8'hF2};
    vecs[9]  = '{"shr8_w0",  8'hFF, 3'd2, 4'd8,  1'b0, 8'h00, 8'h00};
    vecs[10] = '{"asr12_neg",8'h80, 3'd3, 4'd12, 1'b0, 8'h00, 8'hFF};
    vecs[11] = '{"asr15_pos",8'h7F, 3'd3, 4'd15, 1'b1, 8'h00, 8'h00};
    vecs[12] = '{"shl0",     8'h3C, 3'd1, 4'd0,  1'b1, 8'h00, 8'h3C};
    vecs[13] = '{"ror0",     8'h3C, 3'd5, 4'd0,  1'b0, 8'h00, 8'h3C};
    vecs[14] = '{"ror13",    8'h81, 3'd5, 4'd13, 1'b0, 8'h00, 8'h0C};
    vecs[15] = '{"rol8",     8'hA7, 3'd4, 4'd8,  1'b0, 8'h00, 8'hA7};
  end

  initial begin
    logic [7:0] q_before;
    logic       so_exp[4];
    int         cyc;
    int         seen_done;
    int         mq, left, mdone;

    idle_inputs();
    #1;

    // Reset overrides a simultaneous Start and load
    Reset = 1'b1; Start = 1'b1; Count = 4'd5; Mode = 3'd6; I = 8'hFF;
    step();
    step();
    idle_inputs();
    check("reset_q", 32'(Q), 32'h00);
    check("reset_busy", 32'(Busy), 32'h0);
    check("reset_done", 32'(Done), 32'h0);

    for (int k = 0; k < 16; k++) begin
      load(vecs[k].q0);
      Mode = vecs[k].mode; Amount = vecs[k].amt; W = vecs[k].w; I = vecs[k].i;
      step();
      check(vecs[k].name, 32'(Q), 32'(vecs[k].exp));
      idle_inputs();
    end

    // Burst of 4 from B4 with a Start pulse mid-burst that must be ignored
    load(8'hB4);
    so_exp[0] = 1'b0; so_exp[1] = 1'b0; so_exp[2] = 1'b1; so_exp[3] = 1'b0;
    W = 1'b0; Start = 1'b1; Count = 4'd4;
    step();
    Start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("burst_busy%0d", k), 32'(Busy), 32'h1);
      check($sformatf("burst_so%0d", k), 32'(SerialOut), 32'(so_exp[k]));
      check($sformatf("burst_nodone%0d", k), 32'(Done), 32'h0);
      Start = (k == 1); Count = 4'd3;
      step();
      Start = 1'b0;
    end
    check("burst_end_busy", 32'(Busy), 32'h0);
    check("burst_end_done", 32'(Done), 32'h1);
    check("burst_end_q", 32'(Q), 32'h0B);
    step();
    check("burst_done_clear", 32'(Done), 32'h0);
    check("burst_not_queued", 32'(Busy), 32'h0);
    check("burst_q_hold", 32'(Q), 32'h0B);

    // Count=0 gives an immediate Done; Start coincident with Done is accepted
    q_before = Q;
    Start = 1'b1; Count = 4'd0; Mode = 3'd6; I = 8'hEE;
    step();
    check("cnt0_busy", 32'(Busy), 32'h0);
    check("cnt0_done", 32'(Done), 32'h1);
    check("cnt0_q", 32'(Q), 32'(q_before));
    Count = 4'd2; W = 1'b1;
    step();
    Start = 1'b0; Mode = 3'd0;
    check("restart_busy", 32'(Busy), 32'h1);
    check("restart_done_clear", 32'(Done), 32'h0);
    step();
    step();
    check("restart_done", 32'(Done), 32'h1);
    check("restart_q", 32'(Q), 32'(8'hC0 | (q_before >> 2)));
    idle_inputs();
    step();

    // Count larger than N keeps shifting in W
    load(8'h00);
    W = 1'b1; Start = 1'b1; Count = 4'd15;
    step();
    Start = 1'b0;
    cyc = 0;
    while (Busy && cyc < 40) begin
      step();
      cyc++;
    end
    check("long_len", 32'(cyc), 32'd15);
    check("long_q", 32'(Q), 32'hFF);
    check("long_done", 32'(Done), 32'h1);
    idle_inputs();
    step();

    // Reset on the second RUN edge aborts without Done
    load(8'hC3);
    Start = 1'b1; Count = 4'd6;
    step();
    Start = 1'b0;
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("abort_q", 32'(Q), 32'h00);
    check("abort_busy", 32'(Busy), 32'h0);
    seen_done = 0;
    for (int k = 0; k < 8; k++) begin
      if (Done) seen_done = 1;
      step();
    end
    check("abort_no_done", 32'(seen_done), 32'h0);

    // Randomized run against the reference model
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    mq = 0; left = 0; mdone = 0;
    for (int n = 0; n < 600; n++) begin
      Reset  = ($urandom_range(0, 79) == 0);
      Start  = ($urandom_range(0, 9) == 0);
      Count  = 4'($urandom_range(0, 15));
      Mode   = 3'($urandom_range(0, 7));
      Amount = 4'($urandom_range(0, 15));
      W      = 1'($urandom_range(0, 1));
      I      = 8'($urandom_range(0, 255));
      @(posedge Clock);
      if (Reset) begin
        mq = 0; left = 0; mdone = 0;
      end else if (left > 0) begin
        mq = mq / 2 + (W ? 128 : 0);
        left--;
        mdone = (left == 0);
      end else if (Start) begin
        left  = int'(Count);
        mdone = (Count == 4'd0);
      end else begin
        mq    = model_op(mq, int'(Mode), int'(Amount), int'(W), int'(I));
        mdone = 0;
      end
      #1;
      check($sformatf("rnd%0d_q", n), 32'(Q), 32'(mq));
      check($sformatf("rnd%0d_busy", n), 32'(Busy), 32'(left > 0));
      check($sformatf("rnd%0d_done", n), 32'(Done), 32'(mdone));
      check($sformatf("rnd%0d_so", n), 32'(SerialOut), 32'(mq % 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameter N, default 8: register width in bits, N >= 2.
REQ-002 Parameter AW, default 4: width of Amount.
REQ-003 Parameter CW, default 4: width of Count.
REQ-004 Clock  input  1: single clock; all state updates on rising edge.
REQ-005 Reset  input  1: synchronous, active-high reset.
REQ-006 I  input  N: parallel load data.
REQ-007 Mode  input  3: operation select, per REQ-014.
REQ-008 Amount  input  AW: shift/rotate distance for modes 1-5.
REQ-009 W  input  1: serial fill bit.
REQ-010 Start  input  1: burst request.
REQ-011 Count  input  CW: burst length in bits.
REQ-012 Q  output  N: register contents.
REQ-013 SerialOut  output  1: combinational Q[0]; Busy  output  1: burst in progress; Done  output  1: one-cycle burst-complete pulse.

Function
REQ-014 Mode decode in IDLE without Start: 0 hold; 1 shift left by Amount, low bits filled with W; 2 logical shift right by Amount, high bits filled with W; 3 arithmetic shift right by Amount, high bits filled with Q[N-1]; 4 rotate left; 5 rotate right; 6 load I; 7 hold (reserved).
REQ-015 Amount = 0 SHALL leave Q unchanged in modes 1-5.
REQ-016 Amount >= N SHALL give all-W for modes 1-2 and all-Q[N-1] for mode 3.
REQ-017 Amount >= N SHALL rotate by Amount mod N for modes 4-5.
REQ-018 All modes take effect on the edge at which they are sampled: 1-cycle latency, no pipelining.
REQ-019 State machine SHALL have two states: IDLE (Busy=0) and RUN (Busy=1).
REQ-020 IDLE with Start=1 at an edge: Mode ignored, Q unchanged, remaining counter Rem loaded with Count.
REQ-021 At that edge, Count != 0 SHALL go to RUN; Count = 0 SHALL stay IDLE and set Done=1 for the next cycle.
REQ-022 In RUN, each edge: Q <= {W, Q[N-1:1]} (1-bit logical right shift), Rem <= Rem-1; Mode, Amount, I and Start ignored.
REQ-023 The RUN edge with Rem = 1 SHALL perform the final shift, return to IDLE, and set Done=1.
REQ-024 Busy SHALL be high for exactly Count cycles; SerialOut during each RUN cycle is the bit shifted out at the next edge.
REQ-025 Done SHALL be high for exactly one cycle, then clear; a Start coincident with Done=1 in IDLE is accepted normally.
REQ-026 Count > N is legal: shifting continues, filling with W.
REQ-027 Start while Busy SHALL be ignored and not queued.

Reset
REQ-028 Reset=1 at an edge SHALL set Q=0, Busy=0, Done=0, Rem=0 and state IDLE, overriding Start and Mode.
REQ-029 Reset during RUN SHALL abort the burst with no Done pulse.

Verification (N=8, AW=4, CW=4)
REQ-030 Reset, then Mode=6, I=8'hA5 -> Q=8'hA5 after one edge; then Mode=0 -> Q holds 8'hA5.
REQ-031 Q=8'h01, Mode=1, Amount=3, W=1 -> Q=8'h0F; then Q=8'h90, Mode=3, Amount=2 -> Q=8'hE4.
REQ-032 Q=8'h81, Mode=4, Amount=9 -> Q=8'h03; Q=8'h81, Mode=5, Amount=1 -> Q=8'hC0; Q=8'h12, Mode=1, Amount=9, W=1 -> Q=8'hFF.
REQ-033 Q=8'hB4, W=0, Start=1, Count=4 -> Busy=1 for 4 cycles; SerialOut 0,0,1,0; then Done=1 for 1 cycle; final Q=8'h0B; Start pulsed mid-burst has no effect.
REQ-034 Start=1, Count=0 -> Busy stays 0, Done=1 for one cycle, Q unchanged.
REQ-035 Burst Count=6 started, Reset=1 at second RUN edge -> Q=8'h00, Busy=0, Done never asserted.
